i2c_slave: RTL and testbench

Synthesizable I2C target (responder) that answers the existing `i2c_master` on the shared open-drain `scl`/`sda` bus. It replaces the behavioural slave model wherever gate-level or FPGA operation is needed.
- Oversamples the bus on the system clock.
- Detects START, repeated START and STOP.
- Matches a fixed 7-bit address.
- Stores written bytes in a small register file and returns them on reads.

---
 rtl/i2c_slave.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address and a small byte register file, oversampling scl/sda on clk.
// Define I2C_SLAVE_GLITCH_FILTER_EN to insert a 3-sample majority filter after each synchronizer.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         N_REG      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   inout  wire        scl,
   inout  wire        sda,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       addr_hit,
   output logic       busy
);

   localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;
   localparam int PTR_W = IDX_W + 1;
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(N_REG);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
   } state_t;

   logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   logic       scl_bus, sda_bus;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_hist_q <= 3'b111;
         sda_hist_q <= 3'b111;
      end else begin
         scl_hist_q <= scl_hist_d;
         sda_hist_q <= sda_hist_d;
      end
   end
`endif

   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl};
      sda_sync_d = {sda_sync_q[0], sda};
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
      scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
      scl_bus    = maj3(scl_hist_q);
      sda_bus    = maj3(sda_hist_q);
`else
      scl_bus    = scl_sync_q[1];
      sda_bus    = sda_sync_q[1];
`endif
      scl_prev_d = scl_bus;
      sda_prev_d = sda_bus;
   end

   // Idle bus is high, so the input path resets to 1 to avoid a spurious edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_rise  = scl_bus & ~scl_prev_q;
   assign scl_fall  = ~scl_bus & scl_prev_q;
   assign start_det = scl_bus & scl_prev_q & sda_prev_q & ~sda_bus;
   assign stop_det  = scl_bus & scl_prev_q & ~sda_prev_q & sda_bus;

   state_t           state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d, shift_in;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] ptr_idx;
   logic             sda_oe_q, sda_oe_d;
   logic             rw_q, rw_d, ack_q, ack_d, ninth_q, ninth_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             addr_hit_q, addr_hit_d, busy_q, busy_d;
   logic             mem_we;
   logic [7:0]       mem_q [N_REG];

   assign ptr_idx = ptr_q[IDX_W-1:0];

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      sda_oe_d   = sda_oe_q;
      rw_d       = rw_q;
      ack_d      = ack_q;
      ninth_d    = ninth_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      addr_hit_d = addr_hit_q;
      busy_d     = busy_q;
      mem_we     = 1'b0;
      shift_in   = {shift_q[6:0], sda_bus};

      if (start_det) begin
         state_d    = ADDR;
         bit_cnt_d  = 3'd0;
         ptr_d      = '0;
         sda_oe_d   = 1'b0;
         ninth_d    = 1'b0;
         addr_hit_d = 1'b0;
         busy_d     = 1'b1;
      end else if (stop_det) begin
         state_d    = IDLE;
         sda_oe_d   = 1'b0;
         addr_hit_d = 1'b0;
         busy_d     = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            ADDR: begin
               if (scl_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rw_d    = sda_bus;
                     ninth_d = 1'b0;
                     if (shift_q[6:0] == SLAVE_ADDR) begin
                        state_d    = ADDR_ACK;
                        addr_hit_d = 1'b1;
                     end else begin
                        state_d = IGNORE;
                     end
                  end
               end
            end
            // Ack states: the first fall starts the ninth clock, the fall after its rise ends it.
            ADDR_ACK: begin
               if (scl_rise) begin
                  ninth_d = 1'b1;
               end else if (scl_fall) begin
                  if (!ninth_q) begin
                     sda_oe_d = 1'b1;
                  end else if (rw_q) begin
                     state_d   = RD_BYTE;
                     bit_cnt_d = 3'd0;
                     shift_d   = mem_q[ptr_idx];
                     sda_oe_d  = ~mem_q[ptr_idx][7];
                     ptr_d     = {1'b0, ptr_idx + IDX_ONE};
                  end else begin
                     state_d   = WR_BYTE;
                     bit_cnt_d = 3'd0;
                     sda_oe_d  = 1'b0;
                  end
               end
            end
            WR_BYTE: begin
               if (scl_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = WR_ACK;
                     ninth_d = 1'b0;
                     if (ptr_q < PTR_MAX) begin
                        mem_we     = 1'b1;
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        ptr_d      = ptr_q + PTR_W'(1);
                        ack_d      = 1'b1;
                     end else begin
                        ack_d = 1'b0;
                     end
                  end
               end
            end
            WR_ACK: begin
               if (scl_rise) begin
                  ninth_d = 1'b1;
               end else if (scl_fall) begin
                  if (!ninth_q) begin
                     sda_oe_d = ack_q;
                  end else begin
                     state_d   = WR_BYTE;
                     bit_cnt_d = 3'd0;
                     sda_oe_d  = 1'b0;
                  end
               end
            end
            RD_BYTE: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = RD_ACK;
                     ninth_d = 1'b0;
                  end
               end else if (scl_fall) begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = ~shift_q[6];
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  if (sda_bus) state_d = IGNORE;
                  else         ninth_d = 1'b1;
               end else if (scl_fall) begin
                  if (!ninth_q) begin
                     sda_oe_d = 1'b0;
                  end else begin
                     state_d   = RD_BYTE;
                     bit_cnt_d = 3'd0;
                     shift_d   = mem_q[ptr_idx];
                     sda_oe_d  = ~mem_q[ptr_idx][7];
                     ptr_d     = {1'b0, ptr_idx + IDX_ONE};
                  end
               end
            end
            IGNORE:  sda_oe_d = 1'b0;
            default: state_d  = IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         ptr_q      <= '0;
         sda_oe_q   <= 1'b0;
         rw_q       <= 1'b0;
         ack_q      <= 1'b0;
         ninth_q    <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         addr_hit_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         sda_oe_q   <= sda_oe_d;
         rw_q       <= rw_d;
         ack_q      <= ack_d;
         ninth_q    <= ninth_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         addr_hit_q <= addr_hit_d;
         busy_q     <= busy_d;
      end
   end

   // NOTE: the register file must read back 8'h00 after reset, so it is built from resettable flops, not RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REG; i++) mem_q[i] <= 8'h00;
      end else if (mem_we) begin
         mem_q[ptr_idx] <= shift_in;
      end
   end

   assign sda      = sda_oe_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign addr_hit = addr_hit_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged open-drain master drives scl/sda through pull-ups.
module tb_i2c_slave;

   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_scl_low = 1'b0;
   logic       m_sda_low = 1'b0;
   wire        scl_w, sda_w;
   logic [7:0] rx_data;
   logic       rx_valid, addr_hit, busy;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] rx_log [$];
   int         slave_drv = 0;

   logic [7:0] t1_data [3] = '{8'hA1, 8'hB2, 8'hC3};
   logic [7:0] t4_rd   [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h01, 8'h02};

   pullup (scl_w);
   pullup (sda_w);
   assign scl_w = m_scl_low ? 1'b0 : 1'bz;
   assign sda_w = m_sda_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_slave #(.SLAVE_ADDR(7'h50), .N_REG(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl      (scl_w),
      .sda      (sda_w),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .addr_hit (addr_hit),
      .busy     (busy)
   );

   always @(negedge clk) begin
      if (rx_valid === 1'b1) rx_log.push_back(rx_data);
      if (!m_sda_low && sda_w === 1'b0) slave_drv++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic qwait();
      repeat (Q) @(posedge clk);
   endtask

   task automatic bus_start();
      m_sda_low = 1'b0; qwait();
      m_scl_low = 1'b0; qwait();
      m_sda_low = 1'b1; qwait();
      m_scl_low = 1'b1; qwait();
   endtask

   task automatic bus_stop();
      m_scl_low = 1'b1;
      m_sda_low = 1'b1; qwait();
      m_scl_low = 1'b0; qwait();
      m_sda_low = 1'b0; qwait();
      qwait();
   endtask

   task automatic write_bit(input logic b);
      m_sda_low = ~b;   qwait();
      m_scl_low = 1'b0; qwait();
      qwait();
      m_scl_low = 1'b1; qwait();
   endtask

   task automatic read_bit(output logic b);
      m_sda_low = 1'b0; qwait();
      m_scl_low = 1'b0; qwait();
      #1 b = sda_w;
      qwait();
      m_scl_low = 1'b1; qwait();
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(b);
      ack = ~b;
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) read_bit(d[i]);
      write_bit(nack);
   endtask

   initial begin
      logic       ack;
      logic       b;
      logic [7:0] d;
      int         rx_base;
      int         drv_base;

      repeat (3) @(posedge clk);
      #1;
      check("rst_sda",      32'(sda_w),    32'd1);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_addr_hit", 32'(addr_hit), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data",  32'(rx_data),  32'h00);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // Write three bytes
      bus_start();
      check("t1_busy_start", 32'(busy), 32'd1);
      send_byte(8'hA0, ack);
      check("t1_addr_ack", 32'(ack), 32'd1);
      check("t1_addr_hit", 32'(addr_hit), 32'd1);
      for (int i = 0; i < 3; i++) begin
         send_byte(t1_data[i], ack);
         check($sformatf("t1_data_ack%0d", i), 32'(ack), 32'd1);
      end
      bus_stop();
      check("t1_busy_stop", 32'(busy), 32'd0);
      check("t1_rx_count", 32'(rx_log.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         check($sformatf("t1_rx%0d", i), 32'(rx_log[i]), 32'(t1_data[i]));

      // Read them back, NACK the last
      bus_start();
      send_byte(8'hA1, ack);
      check("t2_addr_ack", 32'(ack), 32'd1);
      for (int i = 0; i < 3; i++) begin
         recv_byte(i == 2, d);
         check($sformatf("t2_rd%0d", i), 32'(d), 32'(t1_data[i]));
      end
      #1;
      check("t2_sda_released", 32'(sda_w), 32'd1);
      check("t2_addr_hit_pre", 32'(addr_hit), 32'd1);
      bus_stop();
      check("t2_addr_hit_stop", 32'(addr_hit), 32'd0);

      // Foreign address
      rx_base  = rx_log.size();
      drv_base = slave_drv;
      bus_start();
      send_byte(8'hA2, ack);
      check("t3_addr_nack", 32'(ack), 32'd0);
      send_byte(8'h55, ack);
      check("t3_data_nack", 32'(ack), 32'd0);
      check("t3_busy", 32'(busy), 32'd1);
      check("t3_addr_hit", 32'(addr_hit), 32'd0);
      bus_stop();
      check("t3_busy_stop", 32'(busy), 32'd0);
      check("t3_no_drive", 32'(slave_drv - drv_base), 32'd0);
      check("t3_no_rx", 32'(rx_log.size() - rx_base), 32'd0);

      // Overflow write, then wrapping read
      rx_base = rx_log.size();
      bus_start();
      send_byte(8'hA0, ack);
      check("t4_addr_ack", 32'(ack), 32'd1);
      for (int i = 1; i <= 9; i++) begin
         send_byte(8'(i), ack);
         check($sformatf("t4_wr_ack%0d", i), 32'(ack), (i <= 8) ? 32'd1 : 32'd0);
      end
      bus_stop();
      check("t4_rx_count", 32'(rx_log.size() - rx_base), 32'd8);
      check("t4_rx_data", 32'(rx_data), 32'h08);
      bus_start();
      send_byte(8'hA1, ack);
      check("t4_rd_addr_ack", 32'(ack), 32'd1);
      for (int i = 0; i < 10; i++) begin
         recv_byte(i == 9, d);
         check($sformatf("t4_rd%0d", i), 32'(d), 32'(t4_rd[i]));
      end
      bus_stop();

      // Write then repeated START read
      bus_start();
      send_byte(8'hA0, ack);
      check("t5_addr_ack", 32'(ack), 32'd1);
      send_byte(8'hEE, ack);
      check("t5_data_ack", 32'(ack), 32'd1);
      bus_start();
      check("t5_busy_rs", 32'(busy), 32'd1);
      send_byte(8'hA1, ack);
      check("t5_rd_addr_ack", 32'(ack), 32'd1);
      recv_byte(1'b1, d);
      check("t5_rd", 32'(d), 32'hEE);
      bus_stop();

      // Reset while the slave holds sda low on a read bit (0xEE bit 4)
      bus_start();
      send_byte(8'hA1, ack);
      check("t6_addr_ack", 32'(ack), 32'd1);
      for (int i = 0; i < 3; i++) begin
         read_bit(b);
         check($sformatf("t6_bit%0d", i), 32'(b), 32'd1);
      end
      #1;
      check("t6_slave_low", 32'(sda_w), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_sda", 32'(sda_w), 32'd1);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_addr_hit", 32'(addr_hit), 32'd0);
      check("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
      check("t6_rst_rx_data", 32'(rx_data), 32'h00);
      #2 rst_n = 1'b1;
      bus_stop();
      bus_start();
      send_byte(8'hA1, ack);
      check("t6_post_addr_ack", 32'(ack), 32'd1);
      recv_byte(1'b1, d);
      check("t6_mem_cleared", 32'(d), 32'h00);
      bus_stop();
      check("t6_busy_stop", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
